// File: rtl/op_sequencer_if.sv
// Bundle of the operator panel inputs and the registered operation outputs of op_sequencer.
// state_dbg mirrors the capture FSM state so that checkers can observe it.
interface op_sequencer_if;
    logic [2:0] btn;
    logic [7:0] sw;
    logic [2:0] op_sel;
    logic [3:0] value_a;
    logic [3:0] value_b;
    logic       op_valid;
    logic       busy;
    logic [1:0] state_dbg;

    modport master (
        output btn, sw,
        input  op_sel, value_a, value_b, op_valid, busy, state_dbg
    );

    modport slave (
        input  btn, sw,
        output op_sel, value_a, value_b, op_valid, busy, state_dbg
    );
endinterface

// File: rtl/op_sequencer.sv
// Calculator front end: synchronise/debounce buttons, step op_sel, capture operands, strobe op_valid.
// Optional auto-repeat of held step buttons is enabled by defining OP_SEQ_AUTO_REPEAT_EN.
module op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_OPS         = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    op_sequencer_if.slave   bus
);
    // Handshake: op_valid is a one-cycle strobe with no ready; op_sel/value_a/value_b
    // are stable registers and are valid to sample in the cycle op_valid is high.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, WAIT_REL = 2'd2} state_t;
    state_t state, state_next;

    logic [2:0]    btn_s1, btn_s2;
    logic [7:0]    sw_s1, sw_s2;
    logic [2:0]    deb, deb_q, rise;
    logic [CW-1:0] cnt [3];
    logic          rpt_up, rpt_dn;
    logic          up, dn, do_inc, do_dec, cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= bus.btn;
            btn_s2 <= btn_s1;
            sw_s1  <= bus.sw;
            sw_s2  <= sw_s1;
        end
    end

    // A pending level change must be seen for DEBOUNCE_CYCLES consecutive cycles;
    // any cycle where the synchronised level falls back to the debounced one restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= '0;
            deb_q <= '0;
            rise  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            rise  <= deb & ~deb_q;
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= btn_s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef OP_SEQ_AUTO_REPEAT_EN
    localparam int RPT_FIRST = 16 * DEBOUNCE_CYCLES;
    localparam int RPT_NEXT  = 4 * DEBOUNCE_CYCLES;
    localparam int RW        = $clog2(RPT_FIRST + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_armed;
    logic          rpt_step;
    logic          rpt_hold;

    assign rpt_hold = deb[0] ^ deb[1];

    // rpt_armed marks that the long initial delay has elapsed; later steps use the short period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_step  <= 1'b0;
        end else if (!rpt_hold) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_step  <= 1'b0;
        end else if (rpt_cnt == (rpt_armed ? RW'(RPT_NEXT - 1) : RW'(RPT_FIRST - 1))) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
            rpt_step  <= 1'b1;
        end else begin
            rpt_cnt  <= rpt_cnt + 1'b1;
            rpt_step <= 1'b0;
        end
    end

    assign rpt_up = rpt_step & deb[0];
    assign rpt_dn = rpt_step & deb[1];
`else
    assign rpt_up = 1'b0;
    assign rpt_dn = 1'b0;
`endif

    assign up     = rise[0] | rpt_up;
    assign dn     = rise[1] | rpt_dn;
    assign do_inc = up & ~dn;
    assign do_dec = dn & ~up;
    assign cap    = (state == IDLE) & rise[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (rise[2]) state_next = CAPTURE;
            CAPTURE:  state_next = WAIT_REL;
            WAIT_REL: if (!deb[2]) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs register on entry to CAPTURE so the strobe lands one cycle after the rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.op_sel   <= '0;
            bus.value_a  <= '0;
            bus.value_b  <= '0;
            bus.op_valid <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            if (do_inc)
                bus.op_sel <= (bus.op_sel == 3'(NUM_OPS - 1)) ? 3'd0 : bus.op_sel + 3'd1;
            else if (do_dec)
                bus.op_sel <= (bus.op_sel == 3'd0) ? 3'(NUM_OPS - 1) : bus.op_sel - 3'd1;
            if (cap) begin
                bus.value_a <= sw_s2[3:0];
                bus.value_b <= sw_s2[7:4];
            end
            bus.op_valid <= do_inc | do_dec | cap;
            bus.busy     <= (state_next != IDLE);
        end
    end

    assign bus.state_dbg = state;
endmodule
